// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (seq_alu) and its iterative
// multiply/divide engine (seq_alu_muldiv).
//   - 5-bit opcode map (the same map the single-cycle datapath ALU uses)
//   - FSM state enum for the iterative engine (IDLE, ITER, FIX)
//   - umag(): unsigned magnitude of a two's-complement value
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Working width of umag(). Callers zero-extend their operand to MAG_W and
    // take back the low bits they need, so any operand width up to MAG_W works.
    localparam int MAG_W = 128;

    // Magnitude of a value whose sign is given separately. Negating the
    // zero-extended value leaves the correct magnitude in the low bits,
    // including the most-negative case (which maps onto itself, i.e. 2^(W-1)).
    function automatic logic [MAG_W-1:0] umag(input logic [MAG_W-1:0] v,
                                              input logic             neg);
        umag = neg ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// -----------------------------------------------------------------------------
// seq_alu_muldiv
// Iterative signed multiply (radix-2 Booth) and signed divide (non-restoring)
// engine for seq_alu. One step per clock while in ITER; FIX applies the sign
// correction (divide) or passes the product through (multiply).
//
// Ports:
//   clock   in   system clock, rising edge
//   clear   in   synchronous active-high reset; aborts any operation
//   load    in   begin an operation (only honoured in IDLE)
//   is_div  in   1 = divide, 0 = multiply; sampled with load
//   a, b    in   operands (A = multiplier / dividend, B = multiplicand / divisor)
//   finish  out  high for the single FIX cycle; result is valid while high
//   result  out  MUL: full 2*WIDTH product; DIV: {remainder, quotient}
//
// Sequence: load edge -> WIDTH ITER steps -> one FIX cycle (finish=1).
// -----------------------------------------------------------------------------
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               load,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               finish,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    // Two guard bits: Booth needs one for the (acc - most-negative) case, the
    // divider's shifted partial remainder needs two.
    localparam int AW    = WIDTH + 2;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [AW-1:0]    acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q1_reg;
    logic [WIDTH-1:0] m_reg;

    logic [AW-1:0]    m_sext;
    logic [AW-1:0]    d_ext;
    logic [AW-1:0]    booth_sum;
    logic [AW-1:0]    div_shift;
    logic [AW-1:0]    div_r;
    logic [AW-1:0]    acc_next;
    logic [WIDTH-1:0] q_next;
    logic             q1_next;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // One iteration step for either operation.
    always_comb begin
        m_sext = {{2{m_reg[WIDTH-1]}}, m_reg};
        d_ext  = {2'b00, m_reg};

        // Booth: examine {Q0, Q-1}; 01 adds M, 10 subtracts M.
        case ({q_reg[0], q1_reg})
            2'b01:   booth_sum = acc_reg + m_sext;
            2'b10:   booth_sum = acc_reg - m_sext;
            default: booth_sum = acc_reg;
        endcase

        // Non-restoring: shift the next dividend bit in, then subtract the
        // divisor if the partial remainder is non-negative, otherwise add it.
        div_shift = {acc_reg[AW-2:0], q_reg[WIDTH-1]};
        div_r     = acc_reg[AW-1] ? (div_shift + d_ext) : (div_shift - d_ext);

        if (div_reg) begin
            acc_next = div_r;
            q_next   = {q_reg[WIDTH-2:0], ~div_r[AW-1]};
            q1_next  = q1_reg;
        end else begin
            // Arithmetic right shift of {acc, Q, Q-1}.
            acc_next = {booth_sum[AW-1], booth_sum[AW-1:1]};
            q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};
            q1_next  = q_reg[0];
        end
    end

    // FIX: a negative final remainder needs one restoring add; signs are then
    // reapplied (quotient negative when operand signs differ, remainder takes
    // the dividend's sign).
    always_comb begin
        rem_mag = acc_reg[AW-1] ? WIDTH'(acc_reg + d_ext) : acc_reg[WIDTH-1:0];
        quot    = neg_q_reg ? -q_reg : q_reg;
        rem     = neg_r_reg ? -rem_mag : rem_mag;
        result  = div_reg ? {rem, quot} : {acc_reg[WIDTH-1:0], q_reg};
    end

    assign finish = (state_reg == FIX);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            acc_reg   <= '0;
            q_reg     <= '0;
            q1_reg    <= 1'b0;
            m_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        div_reg   <= is_div;
                        acc_reg   <= '0;
                        q1_reg    <= 1'b0;
                        neg_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r_reg <= a[WIDTH-1];
                        if (is_div) begin
                            // The divider works on magnitudes.
                            q_reg <= WIDTH'(umag(MAG_W'(a), a[WIDTH-1]));
                            m_reg <= WIDTH'(umag(MAG_W'(b), b[WIDTH-1]));
                        end else begin
                            q_reg <= a;
                            m_reg <= b;
                        end
                        cnt_reg   <= CNT_W'(WIDTH);
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    q1_reg  <= q1_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU: single-cycle add/sub/logic/shift/rotate ops plus iterative
// signed multiply and signed divide, behind a start/busy/done handshake.
// Operand A comes from the Y register, operand B from the bus, C goes to Z.
//
// Ports:
//   clock     in   system clock, rising edge
//   clear     in   synchronous active-high reset (aborts any operation)
//   start     in   begin operation; ignored while an operation is in flight
//   opcode    in   5-bit operation select, latched on accepted start
//   A, B      in   WIDTH-bit operands, latched on accepted start
//   C         out  2*WIDTH-bit registered result, held until replaced
//   busy      out  high while MUL/DIV iterates
//   done      out  one-cycle pulse when C is valid
//   div_zero  out  DIV with B=0 (held with C)
//   illegal   out  unmapped opcode (held with C)
//   flag_z/flag_n/flag_v  out  only when SEQ_ALU_FLAGS_EN is defined:
//             zero, negative and signed-overflow flags registered with C
//
// Timing: start accepted at edge k latches the operands; single-cycle ops,
// DIV-by-zero and illegal opcodes write C and pulse done at edge k+1. MUL/DIV
// raise busy at k+1 and finish at k+WIDTH+2.
// WIDTH: power of two, 8..64.
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic               illegal
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_v
`endif
);

    logic [4:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               pend_reg;
    logic [2*WIDTH-1:0] c_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               div_zero_reg;
    logic               illegal_reg;

    logic [SHAMT_W-1:0] sh;
    logic [SHAMT_W-1:0] sh_neg;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_v;
    logic               sc_ok;
    logic               is_mul;
    logic               is_div;
    logic               div0;
    logic               illegal_op;
    logic               md_load;
    logic               accept;
    logic               md_finish;
    logic [2*WIDTH-1:0] md_result;

    // Decode and single-cycle datapath, all on the latched operands.
    always_comb begin
        sh = b_reg[SHAMT_W-1:0];
        // (WIDTH - sh) mod WIDTH: the complementary shift for rotates; for
        // sh=0 both halves shift by 0 and the OR returns the operand.
        sh_neg = ~sh + SHAMT_W'(1);
        sc_res = '0;
        sc_v   = 1'b0;
        sc_ok  = 1'b1;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op_reg)
            OP_ADD, OP_ADDI: begin
                sc_res = a_reg + b_reg;
                sc_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = a_reg - b_reg;
                sc_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_AND, OP_ANDI: sc_res = a_reg & b_reg;
            OP_OR, OP_ORI:   sc_res = a_reg | b_reg;
            OP_ROR:          sc_res = (a_reg >> sh) | (a_reg << sh_neg);
            OP_ROL:          sc_res = (a_reg << sh) | (a_reg >> sh_neg);
            OP_SHR:          sc_res = a_reg >> sh;
            OP_SHRA:         sc_res = $unsigned($signed(a_reg) >>> sh);
            OP_SHL:          sc_res = a_reg << sh;
            OP_NEG: begin
                sc_res = -b_reg;
                sc_v   = (b_reg == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_NOT:          sc_res = ~b_reg;
            OP_MUL: begin
                sc_ok  = 1'b0;
                is_mul = 1'b1;
            end
            OP_DIV: begin
                sc_ok  = 1'b0;
                is_div = 1'b1;
            end
            default:         sc_ok = 1'b0;
        endcase
    end

    assign div0       = is_div && (b_reg == '0);
    assign illegal_op = !sc_ok && !is_mul && !is_div;
    assign md_load    = pend_reg && (is_mul || (is_div && !div0));
    // A MUL/DIV that is being handed to the engine this cycle already counts
    // as in flight, even though busy only rises at this edge.
    assign accept     = start && !busy_reg && !md_load;

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock  (clock),
        .clear  (clear),
        .load   (md_load),
        .is_div (is_div),
        .a      (a_reg),
        .b      (b_reg),
        .finish (md_finish),
        .result (md_result)
    );

`ifdef SEQ_ALU_FLAGS_EN
    logic flag_z_reg;
    logic flag_n_reg;
    logic flag_v_reg;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            pend_reg     <= 1'b0;
            c_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            flag_z_reg   <= 1'b0;
            flag_n_reg   <= 1'b0;
            flag_v_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            pend_reg <= accept;
            if (accept) begin
                op_reg       <= opcode;
                a_reg        <= A;
                b_reg        <= B;
                div_zero_reg <= 1'b0;
                illegal_reg  <= 1'b0;
            end
            if (pend_reg) begin
                if (md_load) begin
                    busy_reg <= 1'b1;
                end else begin
                    // Written after the accept clears so that a completing
                    // op's status wins over a start accepted on the same edge.
                    done_reg     <= 1'b1;
                    div_zero_reg <= div0;
                    illegal_reg  <= illegal_op;
                    if (div0) begin
                        c_reg <= {a_reg, {WIDTH{1'b1}}};
                    end else begin
                        c_reg <= {{WIDTH{1'b0}}, sc_res};
                    end
`ifdef SEQ_ALU_FLAGS_EN
                    // sc_res is zero for illegal opcodes, giving Z=1, N=0.
                    flag_z_reg <= div0 ? 1'b0 : (sc_res == '0);
                    flag_n_reg <= div0 ? a_reg[WIDTH-1] : sc_res[WIDTH-1];
                    flag_v_reg <= sc_v;
`endif
                end
            end else if (md_finish) begin
                c_reg    <= md_result;
                done_reg <= 1'b1;
                busy_reg <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
                flag_z_reg <= (md_result == '0);
                flag_n_reg <= md_result[2*WIDTH-1];
                flag_v_reg <= 1'b0;
`endif
            end
        end
    end

    assign C        = c_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign illegal  = illegal_reg;
`ifdef SEQ_ALU_FLAGS_EN
    assign flag_z   = flag_z_reg;
    assign flag_n   = flag_n_reg;
    assign flag_v   = flag_v_reg;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Table-driven checks of seq_alu (WIDTH=32): a vector table of operands with
// hand-computed results and latencies, plus hand-written sequences for reset,
// start pulses while busy, and clear in the middle of a multiply.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clear = 1'b1;
    logic           start = 1'b0;
    logic [4:0]     opcode = '0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [2*W-1:0] C;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic           illegal;
`ifdef SEQ_ALU_FLAGS_EN
    logic           flag_z;
    logic           flag_n;
    logic           flag_v;
`endif

    int checks = 0;
    int errors = 0;

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .clock    (clk),
        .clear    (clear),
        .start    (start),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .C        (C),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .illegal  (illegal)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_v   (flag_v)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] c;
        logic           dz;
        logic           ill;
        int             lat;
        bit             noisy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done. With noisy set, extra
    // start pulses carrying a different opcode/operands are driven mid-flight.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int busy_cnt;
        logic busy_at_done;
        lat = -1;
        busy_cnt = 0;
        busy_at_done = 1'b1;
        @(negedge clk);
        opcode = v.op;
        A = v.a;
        B = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= W + 10; i++) begin
            if (v.noisy && (i == 1 || i == 5 || i == 20)) begin
                start = 1'b1;
                opcode = OP_ADD;
                A = 32'h1;
                B = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0;
        $display("vec %0d op=%b A=%h B=%h -> C=%h dz=%b ill=%b lat=%0d busy_cycles=%0d",
                 idx, v.op, v.a, v.b, C, div_zero, illegal, lat, busy_cnt);
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d C", idx), C, v.c);
        check($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(v.dz));
        check($sformatf("v%0d illegal", idx), 64'(illegal), 64'(v.ill));
        check($sformatf("v%0d busy_cycles", idx), 64'(busy_cnt), 64'((v.lat > 1) ? v.lat - 1 : 0));
        check($sformatf("v%0d busy_at_done", idx), 64'(busy_at_done), 64'(0));
    endtask

    initial begin
        int dcnt;
        int bcnt;

        // op, A, B, C, div_zero, illegal, latency, noisy
        vecs.push_back(vec_t'{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 64'h00000000_80000000, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_SUB,  32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_00F000F0, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_OR,   32'hF0000000, 32'h0000000F, 64'h00000000_F000000F, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_ROR,  32'h12345678, 32'h00000024, 64'h00000000_81234567, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_ROL,  32'h12345678, 32'h00000004, 64'h00000000_23456781, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_SHR,  32'h80000000, 32'h0000001F, 64'h00000000_00000001, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_SHRA, 32'h80000000, 32'h0000001F, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_SHL,  32'h00000001, 32'h00000021, 64'h00000000_00000002, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_ADDI, 32'h00000010, 32'hFFFFFFFF, 64'h00000000_0000000F, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_NEG,  32'h00000000, 32'h00000005, 64'h00000000_FFFFFFFB, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{5'b11111, 32'h12345678, 32'h9ABCDEF0, 64'h00000000_00000000, 1'b0, 1'b1, 1, 1'b0});
        vecs.push_back(vec_t'{OP_NOT,  32'h00000000, 32'h00000000, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0, 34, 1'b1});
        vecs.push_back(vec_t'{OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_MUL,  32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_DIV,  32'hFFFFFFEF, 32'h00000005, 64'hFFFFFFFE_FFFFFFFD, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_DIV,  32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_DIV,  32'h00000011, 32'hFFFFFFFB, 64'h00000002_FFFFFFFD, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, 34, 1'b0});
        vecs.push_back(vec_t'{OP_DIV,  32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, 1'b1, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_SUB,  32'h00000001, 32'h00000001, 64'h00000000_00000000, 1'b0, 1'b0, 1, 1'b0});
        vecs.push_back(vec_t'{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0, 34, 1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset C", C, 64'h0);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        check("reset illegal", 64'(illegal), 64'(0));
        @(negedge clk);
        clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
`ifdef SEQ_ALU_FLAGS_EN
            if (i == 0) begin
                check("add flag_v", 64'(flag_v), 64'(1));
                check("add flag_n", 64'(flag_n), 64'(1));
                check("add flag_z", 64'(flag_z), 64'(0));
            end
`endif
        end

        // clear at edge k+10 of a MUL: immediate abort, no done afterwards.
        @(negedge clk);
        opcode = OP_MUL;
        A = 32'hFFFFFFFD;
        B = 32'h00000007;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        $display("clear mid-MUL -> C=%h busy=%b done=%b", C, busy, done);
        check("abort C", C, 64'h0);
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        @(negedge clk);
        clear = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        $display("after abort: done pulses=%0d busy cycles=%0d", dcnt, bcnt);
        check("abort no done", 64'(dcnt), 64'(0));
        check("abort no busy", 64'(bcnt), 64'(0));

        run_vec(vec_t'{OP_ADD, 32'h00000002, 32'h00000003, 64'h00000000_00000005, 1'b0, 1'b0, 1, 1'b0}, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle ops use the same 5-bit opcode map; signed multiply (radix-2 Booth) and signed divide (non-restoring) run iteratively.
- Uses a start/busy/done handshake so the control unit can stall until the 2*WIDTH result lands in HI/LO.
- Sits between the Y register (operand A), the bus (operand B) and the Z register (result C).

Parameters:
- WIDTH, 32, operand width; must be a power of 2, ≥8.
- SHAMT_W, $clog2(WIDTH), derived; shift/rotate amount width. Do not override.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only when busy=0.
- opcode  in  5  operation select; latched on accepted start.
- A  in  WIDTH  operand A (Y register); latched on accepted start.
- B  in  WIDTH  operand B (bus or sign-extended immediate); latched on accepted start.
- C  out  2*WIDTH  result; registered; held until the next accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when C is valid.
- div_zero  out  1  set with done for Divide with B=0; held with C.
- illegal  out  1  set with done for an unmapped opcode; held with C.

Behaviour:
- Reset (clear=1 at an edge): C=0, busy=0, done=0, div_zero=0, illegal=0, state=IDLE.
  - clear mid-operation aborts the operation immediately; no done pulse follows.
- Opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011.
  - ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010.
- Single-cycle op semantics:
  - ADD/ADDI: A+B. SUB: A−B. Both mod 2^WIDTH.
  - AND/ANDI: A&B. OR/ORI: A|B.
  - Shifts and rotates use amount B[SHAMT_W-1:0]. SHR is logical, SHRA is arithmetic, SHL is logical.
  - NEG: −B (two's complement). NOT: ~B.
  - C[2W-1:W]=0 for all single-cycle ops.
- MUL: C = signed A × signed B, full 2*WIDTH product.
- DIV: C[W-1:0] = quotient, C[2W-1:W] = remainder.
  - Signed, quotient truncates toward zero.
  - Remainder takes the sign of the dividend A.
- Latency: start accepted at edge k.
  - Single-cycle op or illegal opcode: C/done at edge k+1; busy stays 0.
  - MUL/DIV: busy=1 from edge k+1; C/done at edge k+WIDTH+2; busy=0 on the same edge.
- FSM states:
  - IDLE: on start with MUL/DIV → ITER and load counter=WIDTH. On other start → stay IDLE, write C, pulse done.
  - ITER: one Booth or divide step per cycle; counter decrements; on counter=1 → FIX.
  - FIX: sign correction of quotient/remainder (DIV) or pass-through (MUL). Write C, pulse done, → IDLE.
- start while busy=1: ignored, with no effect on operands or result.
- start at the same edge done pulses (state IDLE at that edge): accepted.
- DIV with B=0: skip iteration, C = {A, all-ones}, div_zero=1, done at edge k+1.
- Overflow case DIV with A=most-negative, B=−1: C = {0, A}, no flag; the iterative path yields this naturally.
- Unmapped opcode: C=0, illegal=1, done at edge k+1.
- div_zero and illegal clear on the next accepted start.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- When defined: add outputs flag_z (C==0), flag_n (C[2W-1] for MUL/DIV, C[W-1] otherwise) and flag_v (signed overflow for ADD/ADDI/SUB/NEG, else 0).
  - Flags are registered alongside C and held.
- When undefined: ports absent, no flag logic.

Decomposition:
- Package alu_pkg: opcode localparams (5-bit), FSM state enum (IDLE, ITER, FIX), helper function for unsigned magnitude.
- One sub-module: seq_alu_muldiv, which owns the ITER/FIX datapath (Booth accumulator, partial remainder, counter).
  - Handshake: load/finish with the top level.
  - The top level holds the single-cycle logic, opcode decode, output registers and flags.

Test Plan (WIDTH=32):
- ADD, A=0x7FFFFFFF, B=1, start → done at k+1, C=0x0000000080000000, busy never 1; with SEQ_ALU_FLAGS_EN: flag_v=1, flag_n=1.
- MUL, A=−3, B=7 → busy k+1..k+33, done at k+34, C=0xFFFFFFFFFFFFFFEB; extra start pulses during busy change nothing.
- DIV, A=−17, B=5 → done k+34, C[31:0]=0xFFFFFFFD (−3), C[63:32]=0xFFFFFFFE (−2); DIV A=100, B=0 → done k+1, div_zero=1, C={0x00000064, 0xFFFFFFFF}.
- ROR A=x, B=0x24 (amount 4) on 0x12345678 → C[31:0]=0x81234567; SHRA 0x80000000 by 31 → 0xFFFFFFFF; SHR 0x80000000 by 31 → 0x00000001.
- clear asserted at k+10 of MUL → next edge: C=0, busy=0, no done pulse; new ADD accepted right after and completes normally.
- opcode 5'b11111 → done k+1, illegal=1, C=0; following NOT B=0 → illegal=0, C[31:0]=0xFFFFFFFF.
